// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the UART transmitter.
//   tx_state_t              : transmitter FSM state encoding
//   PARITY_EVEN/PARITY_ODD  : values of the parity_odd select input
//   UART_DATA_WIDTH         : default data bits per frame
//   UART_DIV_WIDTH          : default width of the baud divisor
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_DIV_WIDTH  = 16;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt -- bit-period down-counter.
//   clk, rst : clock, synchronous active-high reset
//   load     : reload the counter with div (takes priority over counting)
//   div      : bit period minus one, in clocks
//   enable   : count while high
//   bit_end  : high on the last clock of the current bit period
module uart_baud_cnt #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 enable,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = div;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A divisor of zero gives bit_end on every enabled clock.
  assign bit_end = enable && (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- UART transmitter fed directly from a synchronous FIFO read port.
//   clk, rst      : clock, synchronous active-high reset
//   tx_en         : enable; only looked at when deciding to start a frame
//   baud_div      : bit period is baud_div+1 clocks (latched per frame)
//   stop2         : 0 = one stop bit, 1 = two (latched per frame)
//   parity_odd    : 0 = even, 1 = odd parity (only with UART_TX_PARITY_EN)
//   fifo_empty    : FIFO empty flag
//   fifo_rd       : one-cycle FIFO read strobe
//   fifo_rd_data  : FIFO read data, valid from the cycle after fifo_rd
//   tx            : serial output, registered, idles high
//   tx_busy       : high whenever a frame is in progress
//   tx_done       : pulse on the last clock of the final stop bit
// Build option: define UART_TX_PARITY_EN to add the parity bit and port.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  stop2,
`ifdef UART_TX_PARITY_EN
  input  logic                  parity_odd,
`endif
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int BCW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic                  bit_end;
  logic                  baud_load;
  logic                  baud_en;
  logic [DIV_WIDTH-1:0]  baud_src;

  // The divisor is latched on the LOAD edge, so the first (start) bit is
  // loaded straight from the input that is being latched at that moment.
  assign baud_src  = (state_q == LOAD) ? baud_div : div_q;
  assign baud_load = (state_q == LOAD) || bit_end;
  assign baud_en   = (state_q == START) || (state_q == DATA) ||
                     (state_q == PARITY) || (state_q == STOP);

  uart_baud_cnt #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (baud_load),
    .div     (baud_src),
    .enable  (baud_en),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    stop2_d   = stop2_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    fifo_rd   = 1'b0;
    tx_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_en && !fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d   = fifo_rd_data;
        div_d     = baud_div;
        stop2_d   = stop2;
`ifdef UART_TX_PARITY_EN
        par_d     = (^fifo_rd_data) ^ parity_odd;
`endif
        bit_cnt_d = '0;
        state_d   = START;
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          // bit_cnt counts completed stop bits; the last one ends the frame.
          if (bit_cnt_q == (stop2_q ? BCW'(1) : BCW'(0))) begin
            tx_done = 1'b1;
            if (tx_en && !fifo_empty) begin
              fifo_rd = 1'b1;
              state_d = FETCH;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // No strobes while reset is held, so a reset never consumes a FIFO word.
    if (rst) begin
      fifo_rd = 1'b0;
      tx_done = 1'b0;
    end

    // The line level is decoded from the next state so the tx flop lines up
    // with state_q and the output never glitches.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx.
// A frame-level model turns each FIFO word into the per-clock line sequence
// it must produce; one process compares tx/tx_busy/tx_done/fifo_rd against it
// every clock. Directed scenarios add literal checks on timing and bit values.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx;

  localparam int DW = 8;
  localparam int VW = 16;
  localparam int HN = 16384;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_en;
  logic [VW-1:0] baud_div;
  logic          stop2;
`ifdef UART_TX_PARITY_EN
  logic          parity_odd;
`endif
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] fifo_rd_data;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;

  always #5 clk = ~clk;

  uart_tx #(
    .DATA_WIDTH (DW),
    .DIV_WIDTH  (VW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_en        (tx_en),
    .baud_div     (baud_div),
    .stop2        (stop2),
`ifdef UART_TX_PARITY_EN
    .parity_odd   (parity_odd),
`endif
    .fifo_empty   (fifo_empty),
    .fifo_rd      (fifo_rd),
    .fifo_rd_data (fifo_rd_data),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  typedef struct packed {
    logic tx;
    logic last;
  } rec_t;

  rec_t          mq[$];
  logic [DW-1:0] fifo_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            rd_count = 0;
  int            start_log[$];
  int            done_log[$];
  int            fall_log[$];
  logic          hist[0:HN-1];
  bit            chk_en      = 1'b0;
  bit            pop_req     = 1'b0;
  bit            await_start = 1'b0;
  bit            prev_busy   = 1'b0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0b required=%0b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic mpush(input logic v, input logic last);
    rec_t r;
    r.tx   = v;
    r.last = last;
    mq.push_back(r);
  endtask

  // Whole-frame expectation: 2 idle-high fetch clocks, start, data LSB first,
  // optional parity, stop bit(s); every bit lasts baud_div+1 clocks.
  task automatic model_frame(input logic [DW-1:0] b);
    int p;
    int ns;
    p = int'(baud_div) + 1;
    mpush(1'b1, 1'b0);
    mpush(1'b1, 1'b0);
    repeat (p) mpush(1'b0, 1'b0);
    for (int i = 0; i < DW; i++) begin
      repeat (p) mpush(b[i], 1'b0);
    end
`ifdef UART_TX_PARITY_EN
    repeat (p) mpush((^b) ^ parity_odd, 1'b0);
`endif
    ns = (stop2 ? 2 : 1) * p;
    for (int k = 0; k < ns; k++) begin
      mpush(1'b1, k == ns - 1);
    end
  endtask

  // Compare process: model step, per-clock comparison, event logging.
  always @(negedge clk) begin : compare_blk
    rec_t r;
    logic e_tx, e_busy, e_done, e_rd, decide;
    pop_req = (fifo_rd === 1'b1);
    if (chk_en) begin
      if (mq.size() > 0) begin
        r      = mq.pop_front();
        e_tx   = r.tx;
        e_busy = 1'b1;
        e_done = r.last;
        decide = r.last;
      end else begin
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        decide = 1'b1;
      end
      if (rst) e_done = 1'b0;
      e_rd = decide && tx_en && !fifo_empty && !rst;
      chk_bit("tx", tx, e_tx);
      chk_bit("tx_busy", tx_busy, e_busy);
      chk_bit("tx_done", tx_done, e_done);
      chk_bit("fifo_rd", fifo_rd, e_rd);
      if (rst) begin
        mq.delete();
      end else if (e_rd) begin
        model_frame(fifo_q[0]);
      end

      if (cyc < HN) hist[cyc] = tx;
      if (fifo_rd === 1'b1) begin
        rd_count++;
        await_start = 1'b1;
      end
      if (await_start && tx === 1'b0) begin
        start_log.push_back(cyc);
        await_start = 1'b0;
      end
      if (tx_done === 1'b1) done_log.push_back(cyc);
      if (prev_busy && tx_busy === 1'b0) fall_log.push_back(cyc);
      prev_busy = (tx_busy === 1'b1);
      if (rst) await_start = 1'b0;
      cyc++;
    end
  end

  // FIFO with registered read data that holds until the next read.
  always @(posedge clk) begin
    #1;
    if (pop_req && fifo_q.size() > 0) begin
      fifo_rd_data = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    start_log.delete();
    done_log.delete();
    fall_log.delete();
    rd_count = 0;
  endtask

  task automatic wait_start(input int n, input string tag);
    int k;
    k = 0;
    while (start_log.size() < n && k < 300) begin
      tick();
      k++;
    end
    chk_int({tag, "_start_seen"}, (start_log.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((mq.size() != 0 || (tx_en && fifo_q.size() > 0)) && k < 5000) begin
      tick();
      k++;
    end
    chk_int({tag, "_idle_reached"}, (k < 5000) ? 1 : 0, 1);
    repeat (3) tick();
  endtask

  function automatic int st(input int i);
    return (start_log.size() > i) ? start_log[i] : 0;
  endfunction

  function automatic int dn(input int i);
    return (done_log.size() > i) ? done_log[i] : 0;
  endfunction

  function automatic logic hv(input int i);
    return (i >= 0 && i < HN) ? hist[i] : 1'bx;
  endfunction

  initial begin : stim
    int s;
    int got;
    rst          = 1'b1;
    tx_en        = 1'b0;
    baud_div     = VW'(3);
    stop2        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_odd   = uart_pkg::PARITY_EVEN;
`endif
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;

    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk_bit("rst_tx", tx, 1'b1);
    chk_bit("rst_busy", tx_busy, 1'b0);
    chk_bit("rst_done", tx_done, 1'b0);
    chk_bit("rst_rd", fifo_rd, 1'b0);
    repeat (3) tick();

    // 0x55, 4 clocks per bit, one stop bit.
    clr_logs();
    baud_div = VW'(3);
    stop2    = 1'b0;
    fifo_q.push_back(8'h55);
    tx_en = 1'b1;
    wait_start(1, "t1");
    tx_en = 1'b0;
    wait_idle("t1");
    s   = st(0);
    got = 0;
    for (int i = 0; i < 9; i++) got = got | (int'(hv(s + 4 * i)) << i);
    chk_int("t1_bits", got, 'h0AA);
    chk_int("t1_span", dn(0) - s + 1, 40 + 4 * PB);
    chk_bit("t1_stop", hv(dn(0)), 1'b1);
    $display("txn t1 byte=0x55 div=3 start=%0d done=%0d", s, dn(0));

    // Back-to-back 0x01, 0x80 with tx_en held.
    clr_logs();
    baud_div = VW'(2);
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h80);
    tx_en = 1'b1;
    wait_start(1, "t2");
    wait_idle("t2");
    tx_en = 1'b0;
    chk_int("t2_rd_pulses", rd_count, 2);
    chk_int("t2_idle_gap", st(1) - dn(0) - 1, 2);
    chk_bit("t2_gap_high", hv(dn(0) + 1) & hv(dn(0) + 2), 1'b1);
    $display("txn t2 bytes=0x01,0x80 div=2 gap=%0d rd=%0d", st(1) - dn(0) - 1, rd_count);

    // Two stop bits, one clock per bit, 0xFF.
    clr_logs();
    baud_div = VW'(0);
    stop2    = 1'b1;
    fifo_q.push_back(8'hFF);
    tx_en = 1'b1;
    wait_start(1, "t3");
    tx_en = 1'b0;
    wait_idle("t3");
    chk_int("t3_span", dn(0) - st(0) + 1, 11 + PB);
    chk_int("t3_busy_fall", (fall_log.size() > 0) ? fall_log[0] : -1, dn(0) + 1);
    $display("txn t3 byte=0xFF div=0 stop2=1 done=%0d", dn(0));

    // Reset during data bit 4.
    clr_logs();
    baud_div = VW'(3);
    stop2    = 1'b0;
    fifo_q.push_back(8'h3C);
    tx_en = 1'b1;
    wait_start(1, "t4");
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_bit("t4_tx_after_rst", tx, 1'b1);
    chk_bit("t4_busy_after_rst", tx_busy, 1'b0);
    repeat (50) tick();
    chk_int("t4_rd_pulses", rd_count, 1);
    tx_en = 1'b0;
    $display("txn t4 byte=0x3C reset mid-data rd=%0d", rd_count);

    // tx_en dropped during START; a second word stays in the FIFO.
    clr_logs();
    baud_div = VW'(3);
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'h33);
    tx_en = 1'b1;
    wait_start(1, "t5");
    tx_en = 1'b0;
    wait_idle("t5");
    chk_int("t5_rd_pulses", rd_count, 1);
    chk_int("t5_fifo_left", fifo_q.size(), 1);
    chk_int("t5_span", dn(0) - st(0) + 1, 40 + 4 * PB);
    $display("txn t5 byte=0x5A tx_en dropped in start rd=%0d", rd_count);

    // baud_div changed mid-frame.
    clr_logs();
    baud_div = VW'(1);
    tx_en = 1'b1;
    wait_start(1, "t6");
    tx_en = 1'b0;
    repeat (4) tick();
    baud_div = VW'(7);
    wait_idle("t6");
    chk_int("t6_span", dn(0) - st(0) + 1, 20 + 2 * PB);
    chk_int("t6_rd_pulses", rd_count, 1);
    $display("txn t6 byte=0x33 div=1 changed to 7 mid-frame done=%0d", dn(0));

`ifdef UART_TX_PARITY_EN
    // 0xA7 has five ones: even parity bit 1, odd parity bit 0.
    for (int m = 0; m < 2; m++) begin
      clr_logs();
      baud_div   = VW'(1);
      stop2      = 1'b0;
      parity_odd = (m == 1) ? uart_pkg::PARITY_ODD : uart_pkg::PARITY_EVEN;
      fifo_q.push_back(8'hA7);
      tx_en = 1'b1;
      wait_start(1, "tp");
      tx_en = 1'b0;
      wait_idle("tp");
      s = st(0);
      chk_bit("tp_parity_a", hv(s + 18), (m == 1) ? 1'b0 : 1'b1);
      chk_bit("tp_parity_b", hv(s + 19), (m == 1) ? 1'b0 : 1'b1);
      chk_bit("tp_stop", hv(s + 20), 1'b1);
      $display("txn tp byte=0xA7 parity_odd=%0d bit=%0b", m, hv(s + 18));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
